uart_receiver: RTL and testbench

- Serial receive stage downstream of the team's 7-bit UART sender.
- Deserialises one-bit-per-clock frames: start 0, parity, 7 data bits LSB first, stop 1.
- Checks framing and parity, then buffers good characters in a show-ahead FIFO with a valid/ready read port.
- Sits between the serial link and the character consumer.

---
 rtl/uart_receiver.sv | 194 +++++++++++++++++++
 tb/tb_uart_receiver.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   Receive stage for the 7-bit one-bit-per-clock UART link. Deserialises
//   frames (start 0, parity, d0..d6 LSB first, stop 1), checks framing and
//   optionally parity, and buffers good characters in a show-ahead FIFO
//   with a valid/ready read port. Error flags are sticky until err_clr.
//
//   Build option: define UART_RX_PARITY_CHECK_EN to check parity (P must
//   equal XOR of d0..d6). When undefined the parity bit is consumed but
//   ignored and parity_err is tied to 0.
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 2)
//   LVL_W  width of level (must be able to hold DEPTH)
//
// Ports
//   clk         clock, all logic on rising edge
//   rstN        synchronous active-low reset
//   rx          serial line, idle high, one bit per clock
//   rx_ready    consumer accepts head entry when high with rx_valid
//   err_clr     clears the sticky error flags
//   rx_data     FIFO head character (0 when empty)
//   rx_valid    FIFO non-empty
//   level       number of entries held
//   frame_err   sticky: stop bit sampled 0
//   parity_err  sticky: parity mismatch
//   overrun     sticky: good frame dropped because FIFO full
// ---------------------------------------------------------------------------
module uart_receiver #(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             rx,
  input  logic             rx_ready,
  input  logic             err_clr,
  output logic [6:0]       rx_data,
  output logic             rx_valid,
  output logic [LVL_W-1:0] level,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PAR  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_STOP = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  // ---------------- deserialiser FSM ----------------
  logic [2:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       frame_good;
  logic       frame_bad;
  logic       par_ok;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    case (state_q)
      S_IDLE: if (!rx) state_d = S_PAR;
      S_PAR: begin
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        // Shift in from the top: after seven bits d0 sits in bit 0.
        shift_d = {rx, shift_q[6:1]};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd6) state_d = S_STOP;
      end
      S_STOP: begin
        if (rx) begin
          frame_good = 1'b1;
          state_d    = S_IDLE;
        end else begin
          frame_bad = 1'b1;
          state_d   = S_WAIT;
        end
      end
      // Only hunt for a new start bit once the line has returned high.
      S_WAIT: if (rx) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // ---------------- parity (optional) ----------------
`ifdef UART_RX_PARITY_CHECK_EN
  logic par_q;
  logic par_err_q;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      par_q <= 1'b0;
    end else if (state_q == S_PAR) begin
      par_q <= rx;
    end
  end

  assign par_ok = (par_q == ^shift_q);

  // A new error in the err_clr cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= (par_err_q & ~err_clr) | (frame_good & ~par_ok);
    end
  end

  assign parity_err = par_err_q;
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  // ---------------- show-ahead FIFO ----------------
  logic [6:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] count_q, count_d;
  logic             push_req, do_push, pop, full, ovr_new;

  assign push_req = frame_good & par_ok;
  assign full     = (count_q == LVL_W'(DEPTH));
  assign pop      = (count_q != '0) & rx_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
  assign do_push  = push_req & (~full | pop);
  assign ovr_new  = push_req & full & ~pop;

  always_comb begin
    count_d = count_q;
    if (do_push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // ---------------- sticky flags ----------------
  logic frame_err_q, overrun_q;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= (frame_err_q & ~err_clr) | frame_bad;
      overrun_q   <= (overrun_q & ~err_clr) | ovr_new;
    end
  end

  assign rx_valid  = (count_q != '0);
  assign rx_data   = rx_valid ? mem[rd_ptr_q] : 7'd0;
  assign level     = count_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  localparam int DEPTH = 4;
  localparam int LVL_W = 3;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic             rx = 1'b1;
  logic             rx_ready = 1'b0;
  logic             err_clr = 1'b0;
  logic [6:0]       rx_data;
  logic             rx_valid;
  logic [LVL_W-1:0] level;
  logic             frame_err;
  logic             parity_err;
  logic             overrun;

  uart_receiver #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .rx         (rx),
    .rx_ready   (rx_ready),
    .err_clr    (err_clr),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .level      (level),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Reference model: characters the FIFO should hold, in order, plus flags.
  logic [6:0] exp_q[$];
  int         lvl_m = 0;
  logic       frame_m = 1'b0, parity_m = 1'b0, overrun_m = 1'b0;
  logic       ready_idle = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick();
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic parity_of(input logic [6:0] d);
    return logic'($countones(d) % 2);
  endfunction

  // Serialise one frame. Optional rx_ready / err_clr during the stop bit.
  task automatic send_frame(input logic [6:0] d, input logic p, input logic stop,
                            input logic rdy_stop, input logic clr_stop);
    send_bit(1'b0);
    send_bit(p);
    for (int i = 0; i < 7; i++) send_bit(d[i]);
    rx_ready = rdy_stop;
    err_clr  = clr_stop;
    send_bit(stop);
    rx_ready = ready_idle;
    err_clr  = 1'b0;
    rx       = 1'b1;
  endtask

  // Model outcome of a frame whose stop bit was just sampled.
  task automatic apply_frame(input logic [6:0] d, input logic p, input logic stop, input logic clr);
    logic pok;
`ifdef UART_RX_PARITY_CHECK_EN
    pok = ((($countones(d) + int'(p)) % 2) == 0);
`else
    pok = 1'b1;
`endif
    if (clr) begin
      frame_m = 1'b0; parity_m = 1'b0; overrun_m = 1'b0;
    end
    if (!stop) frame_m = 1'b1;
    else if (!pok) parity_m = 1'b1;
    else if (lvl_m == DEPTH) overrun_m = 1'b1;
    else begin
      exp_q.push_back(d);
      lvl_m++;
    end
  endtask

  task automatic frame(input logic [6:0] d, input logic p, input logic stop,
                       input logic rdy_stop, input logic clr_stop);
    send_frame(d, p, stop, rdy_stop, clr_stop);
    apply_frame(d, p, stop, clr_stop);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    tick();
    rx_ready = ready_idle;
  endtask

  task automatic clear_flags();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    frame_m = 1'b0; parity_m = 1'b0; overrun_m = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_frame_err"}, 32'(frame_err), 32'(frame_m));
    check({tag, "_parity_err"}, 32'(parity_err), 32'(parity_m));
    check({tag, "_overrun"}, 32'(overrun), 32'(overrun_m));
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    rx   = 1'b1;
    tick();
    exp_q.delete();
    lvl_m = 0;
    frame_m = 1'b0; parity_m = 1'b0; overrun_m = 1'b0;
    rstN = 1'b1;
  endtask

  // Monitor: compares occupancy every cycle and pops the scoreboard on each
  // accepted handshake.
  always @(negedge clk) begin
    if (rstN === 1'b1) begin
      check("mon_level", 32'(level), 32'(lvl_m));
      check("mon_valid", 32'(rx_valid), 32'(lvl_m != 0));
      if (rx_valid !== 1'b1) check("mon_empty_data", 32'(rx_data), 32'd0);
      if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("mon_unexpected_pop", 32'(rx_data), 32'hFFFF_FFFF);
        end else begin
          check("mon_pop_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        lvl_m--;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] d;
    logic       p, stop, clr;
    int         kind, wait_cnt;

    // Reset values
    rstN = 1'b0;
    tick();
    tick();
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_level", 32'(level), 0);
    check_flags("rst");
    rstN = 1'b1;
    idle(3);

    // Single frame 0x55, then a pop
    frame(7'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t1_valid", 32'(rx_valid), 1);
    check("t1_data", 32'(rx_data), 32'h55);
    check("t1_level", 32'(level), 1);
    pop_one();
    check("t1_valid_after_pop", 32'(rx_valid), 0);
    check("t1_level_after_pop", 32'(level), 0);

    // Five back-to-back frames into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      d = 7'(i);
      frame(d, parity_of(d), 1'b1, 1'b0, 1'b0);
    end
    check("t2_level", 32'(level), 4);
    check("t2_overrun", 32'(overrun), 1);
    for (int i = 0; i < 4; i++) pop_one();
    check("t2_level_drained", 32'(level), 0);
    clear_flags();
    check_flags("t2_clr");

    // Bad parity on 0x01
    frame(7'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    check_flags("t3");
`ifndef UART_RX_PARITY_CHECK_EN
    check("t3_data", 32'(rx_data), 32'h01);
`endif
    while (lvl_m > 0) pop_one();
    clear_flags();

    // Framing error (err_clr in the same cycle must lose), then a good frame
    frame(7'h2A, parity_of(7'h2A), 1'b0, 1'b0, 1'b1);
    rx = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("t4_frame_err", 32'(frame_err), 1);
    check("t4_level_bad", 32'(level), 0);
    idle(1);
    frame(7'h10, parity_of(7'h10), 1'b1, 1'b0, 1'b0);
    check("t4_level_good", 32'(level), 1);
    check("t4_data_good", 32'(rx_data), 32'h10);
    pop_one();
    clear_flags();
    check("t4_frame_err_clr", 32'(frame_err), 0);

    // Reset mid-frame with content and a flag pending
    frame(7'h11, parity_of(7'h11), 1'b1, 1'b0, 1'b0);
    frame(7'h22, parity_of(7'h22), 1'b0, 1'b0, 1'b0);
    idle(1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    do_reset();
    check("t5_rx_data", 32'(rx_data), 0);
    check("t5_rx_valid", 32'(rx_valid), 0);
    check("t5_level", 32'(level), 0);
    check_flags("t5");
    frame(7'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_data", 32'(rx_data), 32'h7F);
    check("t5_level_after", 32'(level), 1);
    pop_one();

    // Push and pop in the same cycle while full
    for (int i = 0; i < 4; i++) begin
      d = 7'(8'h21 + i);
      frame(d, parity_of(d), 1'b1, 1'b0, 1'b0);
    end
    check("t6_full", 32'(level), 4);
    frame(7'h33, parity_of(7'h33), 1'b1, 1'b1, 1'b0);
    check("t6_level", 32'(level), 4);
    check("t6_overrun", 32'(overrun), 0);
    for (int i = 0; i < 3; i++) pop_one();
    check("t6_last", 32'(rx_data), 32'h33);
    pop_one();
    clear_flags();

    // Randomised traffic with the consumer always ready
    ready_idle = 1'b1;
    rx_ready   = 1'b1;
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 5));
      d    = 7'($urandom);
      p    = parity_of(d) ^ (kind == 1);
      stop = (kind != 0);
      clr  = ($urandom_range(0, 7) == 0);
      frame(d, p, stop, 1'b1, clr);
      check_flags("rnd");
      if (!stop) begin
        rx = 1'b0;
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick();
        idle(int'($urandom_range(1, 3)));
      end else begin
        idle(int'($urandom_range(0, 2)));
      end
    end

    // Drain, bounded
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    tick();
    check("drain_queue", 32'(exp_q.size()), 0);
    check("drain_level", 32'(level), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
